// File: rtl/majority_pkg.sv
// Shared types and helpers for the sequential majority voter.
// Holds the filter state encoding, a popcount helper and the default threshold rule.
package majority_pkg;

    typedef enum logic [1:0] {
        S0,
        P1,
        S1,
        P0
    } filt_state_t;

    // Callers zero-extend their vote vector to 32 bits, so NUM_IN is limited to 32.
    function automatic int unsigned popcount(input logic [31:0] i_vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'b0, i_vec[i]};
        end
        return n;
    endfunction

    function automatic int unsigned default_thresh(input int unsigned num_in);
        return (num_in / 2) + 1;
    endfunction

endpackage

// File: rtl/majority_filter.sv
// Hold-count debounce filter for the raw majority decision.
// The filtered output flips only after HOLD consecutive valid samples that oppose it.
module majority_filter
    import majority_pkg::*;
#(
    parameter int HOLD = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic i_raw,
    output logic o_filt
);

    localparam int RUN_W = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] HOLD_V  = RUN_W'(HOLD);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    filt_state_t      r_state;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_next;

    assign w_run_next = r_run + RUN_ONE;

    // Bubbles leave both state and run untouched; only valid samples advance the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
            r_run   <= '0;
            o_filt  <= 1'b0;
        end else if (i_valid) begin
            case (r_state)
                S0: begin
                    if (i_raw) begin
                        if (HOLD == 1) begin
                            r_state <= S1;
                            o_filt  <= 1'b1;
                        end else begin
                            r_state <= P1;
                            r_run   <= RUN_ONE;
                        end
                    end
                end
                P1: begin
                    if (i_raw) begin
                        if (w_run_next == HOLD_V) begin
                            r_state <= S1;
                            r_run   <= '0;
                            o_filt  <= 1'b1;
                        end else begin
                            r_run <= w_run_next;
                        end
                    end else begin
                        r_state <= S0;
                        r_run   <= '0;
                    end
                end
                S1: begin
                    if (!i_raw) begin
                        if (HOLD == 1) begin
                            r_state <= S0;
                            o_filt  <= 1'b0;
                        end else begin
                            r_state <= P0;
                            r_run   <= RUN_ONE;
                        end
                    end
                end
                P0: begin
                    if (!i_raw) begin
                        if (w_run_next == HOLD_V) begin
                            r_state <= S0;
                            r_run   <= '0;
                            o_filt  <= 1'b0;
                        end else begin
                            r_run <= w_run_next;
                        end
                    end else begin
                        r_state <= S1;
                        r_run   <= '0;
                    end
                end
                default: begin
                    r_state <= S0;
                    r_run   <= '0;
                    o_filt  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/majority_voter_seq.sv
// Two-stage clocked N-input majority voter with debounced output
// and per-input saturating disagreement counters.
module majority_voter_seq
    import majority_pkg::*;
#(
    parameter int NUM_IN = 5,
    parameter int THRESH = default_thresh(NUM_IN),
    parameter int HOLD   = 3,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_in_valid,
    input  logic [NUM_IN-1:0]         i_in_votes,
    input  logic                      i_clr_cnt,
    output logic                      o_out_valid,
    output logic                      o_maj_raw,
    output logic                      o_maj_filt,
    output logic [NUM_IN-1:0]         o_disagree,
    output logic [NUM_IN*CNT_W-1:0]   o_err_cnt
);

    localparam int CW = $clog2(NUM_IN + 1);
    localparam logic [CW-1:0]    THRESH_V = CW'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              r_s1_valid;
    logic [NUM_IN-1:0] r_s1_votes;
    logic [CW-1:0]     r_s1_count;
    logic [CW-1:0]     w_count;
    logic              w_raw;
    logic [NUM_IN-1:0] w_disagree;
    logic [CNT_W-1:0]  r_err_cnt [NUM_IN];

    assign w_count    = CW'(popcount(32'(i_in_votes)));
    assign w_raw      = (r_s1_count >= THRESH_V);
    assign w_disagree = r_s1_votes ^ {NUM_IN{w_raw}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_votes <= '0;
            r_s1_count <= '0;
        end else begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_votes <= i_in_votes;
                r_s1_count <= w_count;
            end
        end
    end

    // Decision outputs hold their last value across bubbles; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_out_valid <= 1'b0;
            o_maj_raw   <= 1'b0;
            o_disagree  <= '0;
        end else begin
            o_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_maj_raw  <= w_raw;
                o_disagree <= w_disagree;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_err_cnt[i] <= '0;
            end
        end else if (i_clr_cnt) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_err_cnt[i] <= '0;
            end
        end else if (r_s1_valid) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_disagree[i] && (r_err_cnt[i] != CNT_MAX)) begin
                    r_err_cnt[i] <= r_err_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_pack
        assign o_err_cnt[g*CNT_W +: CNT_W] = r_err_cnt[g];
    end

    majority_filter #(
        .HOLD (HOLD)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_s1_valid),
        .i_raw   (w_raw),
        .o_filt  (o_maj_filt)
    );

endmodule

// File: tb/tb_majority_voter_seq.sv
// Directed self-checking bench for majority_voter_seq (NUM_IN=5, HOLD=3, CNT_W=2),
// with a second THRESH=5 instance sharing the same stimulus.
module tb_majority_voter_seq;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        inValid = 1'b0;
    logic [4:0]  inVotes = '0;
    logic        clrCnt = 1'b0;

    logic        outValid, majRaw, majFilt;
    logic [4:0]  disagree;
    logic [9:0]  errCnt;

    logic        tOutValid, tMajRaw, tMajFilt;
    logic [4:0]  tDisagree;
    logic [9:0]  tErrCnt;

    int checkCount = 0;
    int failCount  = 0;

    logic [4:0] filtVotes [6];
    logic       expFilt   [6];
    logic [1:0] expSat    [5];

    always #5 clk = ~clk;

    majority_voter_seq #(
        .NUM_IN (5),
        .HOLD   (3),
        .CNT_W  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .i_in_valid  (inValid),
        .i_in_votes  (inVotes),
        .i_clr_cnt   (clrCnt),
        .o_out_valid (outValid),
        .o_maj_raw   (majRaw),
        .o_maj_filt  (majFilt),
        .o_disagree  (disagree),
        .o_err_cnt   (errCnt)
    );

    majority_voter_seq #(
        .NUM_IN (5),
        .THRESH (5),
        .HOLD   (3),
        .CNT_W  (2)
    ) dutT (
        .clk         (clk),
        .rst_n       (rstN),
        .i_in_valid  (inValid),
        .i_in_votes  (inVotes),
        .i_clr_cnt   (clrCnt),
        .o_out_valid (tOutValid),
        .o_maj_raw   (tMajRaw),
        .o_maj_filt  (tMajFilt),
        .o_disagree  (tDisagree),
        .o_err_cnt   (tErrCnt)
    );

    // Drives one cycle of inputs, waits for the capturing edge, then settles 1 ns past it.
    task automatic applyStimulus(input logic v, input logic [4:0] votes, input logic clr);
        inValid = v;
        inVotes = votes;
        clrCnt  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One valid sample followed by one bubble; its results are visible on return.
    task automatic runSample(input logic [4:0] votes);
        applyStimulus(1'b1, votes, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b0);
    endtask

    task automatic doReset;
        rstN = 1'b0;
        applyStimulus(1'b0, 5'b00000, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b0);
        rstN = 1'b1;
    endtask

    initial begin
        filtVotes = '{5'b11111, 5'b11111, 5'b00000, 5'b11111, 5'b11111, 5'b11111};
        expFilt   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expSat    = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset held with random valid votes
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        checkOutput("rst_valid", 16'(outValid), 16'd0);
        checkOutput("rst_raw", 16'(majRaw), 16'd0);
        checkOutput("rst_filt", 16'(majFilt), 16'd0);
        checkOutput("rst_disagree", 16'(disagree), 16'd0);
        checkOutput("rst_errcnt", 16'(errCnt), 16'd0);
        rstN = 1'b1;
        applyStimulus(1'b0, 5'b00000, 1'b0);

        // First sample and its latency
        applyStimulus(1'b1, 5'b00111, 1'b0);
        checkOutput("lat_early_valid", 16'(outValid), 16'd0);
        applyStimulus(1'b0, 5'b00000, 1'b0);
        checkOutput("lat_valid", 16'(outValid), 16'd1);
        checkOutput("first_raw", 16'(majRaw), 16'd1);
        checkOutput("first_disagree", 16'(disagree), 16'b11000);
        checkOutput("first_errcnt", 16'(errCnt), 16'h140);
        checkOutput("first_filt", 16'(majFilt), 16'd0);
        applyStimulus(1'b0, 5'b00000, 1'b0);
        checkOutput("bubble_valid", 16'(outValid), 16'd0);
        checkOutput("bubble_raw_hold", 16'(majRaw), 16'd1);
        checkOutput("bubble_disagree_hold", 16'(disagree), 16'b11000);

        // Threshold sweep
        runSample(5'b00011);
        checkOutput("thr_cnt2_raw", 16'(majRaw), 16'd0);
        checkOutput("thr_cnt2_disagree", 16'(disagree), 16'b00011);
        checkOutput("thr5_cnt2_raw", 16'(tMajRaw), 16'd0);
        runSample(5'b10101);
        checkOutput("thr_cnt3_raw", 16'(majRaw), 16'd1);
        checkOutput("thr_cnt3_disagree", 16'(disagree), 16'b01010);
        checkOutput("thr5_cnt3_raw", 16'(tMajRaw), 16'd0);
        runSample(5'b11110);
        checkOutput("thr_cnt4_raw", 16'(majRaw), 16'd1);
        checkOutput("thr5_cnt4_raw", 16'(tMajRaw), 16'd0);
        checkOutput("thr5_cnt4_disagree", 16'(tDisagree), 16'b11110);
        runSample(5'b11111);
        checkOutput("thr5_cnt5_raw", 16'(tMajRaw), 16'd1);

        // Filter, back-to-back samples: result of sample k-1 visible after call k
        doReset();
        for (int k = 0; k < 7; k++) begin
            applyStimulus(k < 6, (k < 6) ? filtVotes[k] : 5'b00000, 1'b0);
            if (k >= 1) begin
                checkOutput($sformatf("filt_b2b_valid_%0d", k - 1), 16'(outValid), 16'd1);
                checkOutput($sformatf("filt_b2b_%0d", k - 1), 16'(majFilt), 16'(expFilt[k - 1]));
            end
        end

        // Filter, bubbles interleaved
        doReset();
        for (int k = 0; k < 6; k++) begin
            runSample(filtVotes[k]);
            checkOutput($sformatf("filt_bub_%0d", k), 16'(majFilt), 16'(expFilt[k]));
        end

        // Saturation of input 0's counter
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(k < 5, (k < 5) ? 5'b11110 : 5'b00000, 1'b0);
            if (k >= 1) begin
                checkOutput($sformatf("sat_cnt0_%0d", k - 1), 16'(errCnt[1:0]), 16'(expSat[k - 1]));
            end
        end
        checkOutput("sat_cnt1", 16'(errCnt[3:2]), 16'd0);

        // Clear coinciding with an increment, then a fresh increment
        applyStimulus(1'b1, 5'b11110, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkOutput("clr_valid", 16'(outValid), 16'd1);
        checkOutput("clr_cnt0", 16'(errCnt[1:0]), 16'd0);
        checkOutput("clr_filt", 16'(majFilt), 16'd1);
        runSample(5'b11110);
        checkOutput("clr_next_cnt0", 16'(errCnt[1:0]), 16'd1);

        // Mid-stream reset with the filter primed at run 2
        doReset();
        applyStimulus(1'b1, 5'b11111, 1'b0);
        applyStimulus(1'b1, 5'b11111, 1'b0);
        applyStimulus(1'b1, 5'b11111, 1'b0);
        rstN = 1'b0;
        applyStimulus(1'b0, 5'b00000, 1'b0);
        checkOutput("mid_rst_valid", 16'(outValid), 16'd0);
        checkOutput("mid_rst_raw", 16'(majRaw), 16'd0);
        checkOutput("mid_rst_filt", 16'(majFilt), 16'd0);
        rstN = 1'b1;
        applyStimulus(1'b0, 5'b00000, 1'b0);
        checkOutput("mid_post_valid", 16'(outValid), 16'd0);
        runSample(5'b11111);
        checkOutput("mid_s0_filt_1", 16'(majFilt), 16'd0);
        runSample(5'b11111);
        checkOutput("mid_s0_filt_2", 16'(majFilt), 16'd0);
        runSample(5'b11111);
        checkOutput("mid_s0_filt_3", 16'(majFilt), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
        $finish;
    end

endmodule
